// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: memory-stage controller for Load-Multiple / Store-Multiple.
// Latches a base address and register list, then runs one memory transfer per
// cycle (lowest selected register first, consecutive addresses) while holding
// the upstream pipeline stalled. A downstream hold freezes progress in place.
//
// Handshake: start is a request taken only while idle (stall_req answers it in
// the same cycle); once busy, start is ignored until the sequencer has passed
// through DONE and is back in IDLE. There is no ready back-pressure on start.
module lm_sm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LIST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_store,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic              busy,
  output logic              stall_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        reg_idx,
  output logic              mem_we,
  output logic              rf_we,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LIST_W-1:0]   mask_q, mask_d;
  logic                op_q, op_d;

  logic [2:0]          low_idx;
  logic [LIST_W-1:0]   mask_cleared;
  logic                in_idle;
  logic                in_xfer;
  logic                xfer_go;

  // Lowest set bit of the pending mask selects the register for this transfer.
  always_comb begin
    low_idx = 3'd0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_idx = 3'(i);
      end
    end
  end

  // Next-state and datapath update; clearing the lowest set bit via m & (m-1).
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mask_d       = mask_q;
    op_d         = op_q;
    mask_cleared = mask_q & (mask_q - LIST_W'(1));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          mask_d  = reg_list;
          op_d    = op_store;
          state_d = (reg_list == '0) ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        if (!hold) begin
          mask_d = mask_cleared;
          addr_d = addr_q + ADDR_W'(1);
          if (mask_cleared == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; synchronous reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      op_q    <= op_d;
    end
  end

  // Output decode; strobes and done are masked in a reset cycle so an abort
  // never produces a partial transfer or a completion pulse.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    in_xfer   = (state_q == ST_XFER);
    xfer_go   = in_xfer & ~hold & ~reset;
    busy      = ~in_idle;
    stall_req = ~in_idle | start;
    mem_we    = xfer_go & op_q;
    rf_we     = xfer_go & ~op_q;
    done      = (state_q == ST_DONE) & ~reset;
    mem_addr  = addr_q;
    reg_idx   = in_xfer ? low_idx : 3'd0;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed scenarios followed by
// randomized LM/SM runs with random holds, ignored start pulses and resets,
// all compared cycle by cycle against a queue-based transfer model.
module tb_lm_sm_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_store;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        hold;
  logic        busy;
  logic        stall_req;
  logic [15:0] mem_addr;
  logic [2:0]  reg_idx;
  logic        mem_we;
  logic        rf_we;
  logic        done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  // Memory and register file emulated around the DUT.
  logic [15:0] tb_mem [0:65535];
  logic [15:0] tb_rf  [0:7];

  // Reference model: pending transfers as a queue of (address, register).
  typedef struct packed {
    logic [15:0] a;
    logic [2:0]  r;
  } xfer_t;
  xfer_t       m_q[$];
  bit          m_done;
  bit          m_op;
  bit          m_known;
  logic [15:0] m_addr;

  lm_sm_sequencer #(.ADDR_W(16), .LIST_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_store  (op_store),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .hold      (hold),
    .busy      (busy),
    .stall_req (stall_req),
    .mem_addr  (mem_addr),
    .reg_idx   (reg_idx),
    .mem_we    (mem_we),
    .rf_we     (rf_we),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory / RF side effects of DUT strobes.
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= tb_rf[reg_idx];
    if (rf_we)  tb_rf[reg_idx]   <= tb_mem[mem_addr];
    if (mem_we || rf_we) n_xfer <= n_xfer + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input bit r, input bit s, input bit op, input logic [7:0] list,
                      input logic [15:0] base, input bit h);
    bit running;
    bit e_busy;
    int k;
    @(negedge clk);
    reset = r; start = s; op_store = op; reg_list = list; base_addr = base; hold = h;
    #1;
    running = (m_q.size() != 0);
    e_busy  = running | m_done;
    if (m_known) begin
      check_eq("busy",      busy, e_busy);
      check_eq("stall_req", stall_req, e_busy | s);
      check_eq("mem_we",    mem_we, running & !h & !r & m_op);
      check_eq("rf_we",     rf_we,  running & !h & !r & !m_op);
      check_eq("done",      done,   m_done & !r);
      check_eq("mem_addr",  mem_addr, running ? m_q[0].a : m_addr);
      check_eq("reg_idx",   reg_idx,  running ? m_q[0].r : 3'd0);
    end
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_done  = 0;
      m_op    = 0;
      m_addr  = '0;
      m_known = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (running) begin
      if (!h) begin
        m_addr = m_q[0].a + 16'd1;
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1;
      end
    end else if (s) begin
      m_addr = base;
      m_op   = op;
      k = 0;
      for (int i = 0; i < 8; i++) begin
        if (list[i]) begin
          m_q.push_back('{a: base + 16'(k), r: 3'(i)});
          k++;
        end
      end
      if (k == 0) m_done = 1;
    end
  endtask

  // Driver: start one LM/SM and run until the model is idle again.
  // hold_pat bit c holds in cycle c; reset_at>0 asserts reset in that cycle.
  task automatic run_op(input bit op, input logic [7:0] list, input logic [15:0] base,
                        input logic [31:0] hold_pat, input bit noise, input int reset_at);
    int c;
    step(0, 1, op, list, base, 0);
    c = 1;
    while ((m_q.size() != 0 || m_done) && c < 200) begin
      step(c == reset_at, noise ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom),
           8'($urandom), 16'($urandom), (c < 32) ? hold_pat[c] : 1'b0);
      c++;
    end
    if (c >= 200) check_eq("timeout", 1, 0);
  endtask

  int base_cnt;

  initial begin
    reset = 0; start = 0; op_store = 0; reg_list = 0; base_addr = 0; hold = 0;
    m_done = 0; m_op = 0; m_known = 0; m_addr = 0;
    for (int i = 0; i < 65536; i++) tb_mem[i] = 16'(i ^ 16'h5A5A);
    for (int i = 0; i < 8; i++) tb_rf[i] = 16'hA000 + 16'(i);

    // Reset for two cycles, then one idle cycle.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // SM of R0, R1, R3 at 0x0040.
    run_op(1, 8'h0B, 16'h0040, 32'h0, 0, 0);
    check_eq("sm_mem40", tb_mem[16'h0040], 16'hA000);
    check_eq("sm_mem41", tb_mem[16'h0041], 16'hA001);
    check_eq("sm_mem42", tb_mem[16'h0042], 16'hA003);
    check_eq("sm_mem43", tb_mem[16'h0043], 16'h0043 ^ 16'h5A5A);

    // LM of R0, R7 from 0x0100 with a hold in cycle 2.
    run_op(0, 8'h81, 16'h0100, 32'h4, 0, 0);
    check_eq("lm_r0", tb_rf[0], 16'h0100 ^ 16'h5A5A);
    check_eq("lm_r7", tb_rf[7], 16'h0101 ^ 16'h5A5A);
    check_eq("lm_r1", tb_rf[1], 16'hA001);

    // Empty list, then a full list with start pulses while busy.
    run_op(1, 8'h00, 16'h1234, 32'h0, 0, 0);
    base_cnt = n_xfer;
    run_op(1, 8'hFF, 16'h2000, 32'h0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("ff_xfer_cnt", n_xfer - base_cnt, 8);

    // Address wrap.
    run_op(1, 8'h07, 16'hFFFE, 32'h0, 0, 0);
    check_eq("wrap_fffe", tb_mem[16'hFFFE], tb_rf[0]);
    check_eq("wrap_ffff", tb_mem[16'hFFFF], tb_rf[1]);
    check_eq("wrap_0000", tb_mem[16'h0000], tb_rf[2]);

    // Reset in cycle 3 of a full-list run: exactly two transfers.
    base_cnt = n_xfer;
    run_op(0, 8'hFF, 16'h3000, 32'h0, 0, 3);
    step(0, 0, 0, 0, 0, 0);
    check_eq("rst_xfer_cnt", n_xfer - base_cnt, 2);

    // Randomized runs.
    for (int it = 0; it < 60; it++) begin
      logic [7:0] l;
      l = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      run_op(1'($urandom), l, 16'($urandom), $urandom & $urandom, 1,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0);
      if ($urandom_range(0, 1) == 1) step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle controller for the memory stage that sequences Load-Multiple (LM) and Store-Multiple (SM) instructions over the single-port data memory. It latches a base address and an 8-bit register list, then issues one memory transfer per cycle. Each transfer uses the next consecutive address and the next selected register. While it runs, it asserts a stall to freeze the upstream pipeline. It drives the memory-stage read/write address selection, the memory write enable, and the register-file write port for LM.

## Interface
Parameters:
- ADDR_W, 16, data-memory address width; addresses wrap modulo 2^ADDR_W.
- LIST_W, 8, register-list width; bit i selects register Ri.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; all state cleared on the edge where reset=1.
- start  in  1  request to begin an LM/SM; sampled only in IDLE.
- op_store  in  1  1 = SM (register -> memory), 0 = LM (memory -> register); sampled with start.
- reg_list  in  LIST_W  register selection mask (instruction imm field); sampled with start.
- base_addr  in  ADDR_W  first memory address (RA operand value); sampled with start.
- hold  in  1  downstream stall; freezes the sequencer in XFER with no transfer that cycle.
- busy  out  1  1 whenever state != IDLE.
- stall_req  out  1  busy | (start & state==IDLE); fetch/decode freeze.
- mem_addr  out  ADDR_W  current transfer address, routed to both read and write address muxes.
- reg_idx  out  3  register index for the current transfer (RF read port for SM, RF write address for LM).
- mem_we  out  1  data-memory write strobe (SM transfer).
- rf_we  out  1  register-file write strobe (LM transfer).
- done  out  1  one-cycle pulse after the final transfer, or for an empty list.

## Operation
- States: IDLE, XFER, DONE. Encoding is free.
- IDLE: if start=1, latch addr_q<=base_addr, mask_q<=reg_list, op_q<=op_store.
  - If reg_list==0, go to DONE. Otherwise go to XFER.
  - start=0: stay in IDLE.
- XFER: reg_idx = index of the lowest set bit of mask_q (R0 first, R7 last); mem_addr = addr_q.
  - hold=0: the transfer occurs. mem_we=op_q and rf_we=~op_q. Clear that bit in mask_q. addr_q <= addr_q+1.
  - If the cleared bit was the last set bit, go to DONE. Otherwise stay in XFER.
  - hold=1: mem_we=rf_we=0; mask_q, addr_q and state are unchanged.
- DONE: done=1 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- start is ignored while busy=1. A new request is accepted no earlier than the cycle after DONE.
- Address arithmetic is unsigned ADDR_W-bit. 0xFFFF+1 = 0x0000 with no carry or flag.
- Outside XFER: mem_we=rf_we=0. mem_addr and reg_idx are don't-care but must not be X.
  - Drive them as addr_q and 0 respectively.
- Only the lowest set bit is ever selected. Registers are transferred in ascending index order regardless of list bit pattern (e.g. 0x81 transfers R0 then R7).

## Timing
- Reset values: state=IDLE, addr_q=0, mask_q=0, op_q=0.
  - Outputs: busy=0, stall_req=0, mem_we=0, rf_we=0, done=0, mem_addr=0, reg_idx=0.
- Reset is synchronous and has priority over all inputs. Reset in XFER or DONE aborts immediately.
  - No further mem_we, rf_we or done is produced. The cycle after reset is IDLE.
- Latency: for N set bits and no hold, start at cycle 0 gives transfers in cycles 1..N and done in cycle N+1. The sequencer is back in IDLE at cycle N+2.
- Empty list: start at cycle 0 gives done at cycle 1, with no transfers.
- Each hold cycle extends the sequence by exactly one cycle.
- stall_req rises combinationally in the start cycle. It stays high through the DONE cycle.
- Memory writes commit on the rising edge that ends the mem_we cycle. LM data is combinational from memory and is written to the RF on the same edge.
- All state updates occur on the rising edge of clk only.

## Test plan
- Reset: hold reset=1 for 2 cycles, then release. Check busy=0, mem_we=rf_we=done=0, mem_addr=0, reg_idx=0.
- SM: base_addr=0x0040, reg_list=0x0B, op_store=1.
  - Cycles 1-3: mem_we=1 with (addr,reg) = (0x0040,0), (0x0041,1), (0x0042,3).
  - done at cycle 4; memory holds R0, R1, R3 at those addresses.
- LM with hold: base_addr=0x0100, reg_list=0x81, op_store=0, hold=1 in cycle 2.
  - rf_we at cycle 1 (R0 <- mem[0x0100]) and cycle 3 (R7 <- mem[0x0101]).
  - Nothing is written in cycle 2. done at cycle 4.
- Empty list and ignored start: reg_list=0x00 gives done at cycle 1 with no strobes. A start pulsed during busy of a 0xFF run is ignored; exactly 8 transfers occur.
- Wrap: base_addr=0xFFFE, reg_list=0x07, op_store=1 writes addresses 0xFFFE, 0xFFFF, 0x0000.
- Reset mid-op: reg_list=0xFF with reset asserted at cycle 3. Exactly 2 transfers occur, no done pulse, busy=0 at cycle 4.
